genesis_pad_emulator: RTL and testbench



---
 rtl/genesis_pad_pkg.sv | 86 ++++++++
 rtl/genesis_sync_edge.sv | 40 ++++
 rtl/genesis_pad_emulator.sv | 98 +++++++++
 tb/tb_genesis_pad_emulator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/genesis_pad_pkg.sv
// genesis_pad_pkg
//   Definitions shared by the pad emulator and the host-side reader:
//   button bit positions in the 12-bit button vector, the default Select
//   inactivity timeout, the Fase values with special pin maps, and the
//   pad pin map helper.
package genesis_pad_pkg;

    // Bit positions inside the 12-bit button vector (1 = pressed)
    localparam int unsigned BTN_MODE  = 0;
    localparam int unsigned BTN_START = 1;
    localparam int unsigned BTN_Z     = 2;
    localparam int unsigned BTN_Y     = 3;
    localparam int unsigned BTN_X     = 4;
    localparam int unsigned BTN_C     = 5;
    localparam int unsigned BTN_B     = 6;
    localparam int unsigned BTN_A     = 7;
    localparam int unsigned BTN_RIGHT = 8;
    localparam int unsigned BTN_LEFT  = 9;
    localparam int unsigned BTN_DOWN  = 10;
    localparam int unsigned BTN_UP    = 11;

    // 1.5 ms of clock_50 without a Select falling edge
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 75000;

    // Fase values with special meaning on a 6-button pad
    localparam logic [2:0] FASE_ID  = 3'd3;  // low: ID (P1..P4 low), high: Z/Y/X/Mode
    localparam logic [2:0] FASE_EXT = 3'd4;  // low: P1..P4 released
    localparam logic [2:0] FASE_MAX = 3'd7;

    typedef struct packed {
        logic p1;
        logic p2;
        logic p3;
        logic p4;
        logic p6;
        logic p9;
    } pad_pins_t;

    // Active-low pin levels for a given Select level, Fase and button vector.
    function automatic pad_pins_t pad_map(
        input logic        sel,
        input logic [2:0]  fase,
        input logic [11:0] btn,
        input logic        six_btn
    );
        pad_pins_t p;
        p = '1;
        if (sel) begin
            if (six_btn && (fase == FASE_ID)) begin
                p.p1 = ~btn[BTN_Z];
                p.p2 = ~btn[BTN_Y];
                p.p3 = ~btn[BTN_X];
                p.p4 = ~btn[BTN_MODE];
            end else begin
                p.p1 = ~btn[BTN_UP];
                p.p2 = ~btn[BTN_DOWN];
                p.p3 = ~btn[BTN_LEFT];
                p.p4 = ~btn[BTN_RIGHT];
            end
            p.p6 = ~btn[BTN_B];
            p.p9 = ~btn[BTN_C];
        end else begin
            if (six_btn && (fase == FASE_ID)) begin
                p.p1 = 1'b0;
                p.p2 = 1'b0;
                p.p3 = 1'b0;
                p.p4 = 1'b0;
            end else if (six_btn && (fase == FASE_EXT)) begin
                p.p1 = 1'b1;
                p.p2 = 1'b1;
                p.p3 = 1'b1;
                p.p4 = 1'b1;
            end else begin
                // Plain 3-button low map; also covers Fase 0 before the first edge
                p.p1 = ~btn[BTN_UP];
                p.p2 = ~btn[BTN_DOWN];
                p.p3 = 1'b0;
                p.p4 = 1'b0;
            end
            p.p6 = ~btn[BTN_A];
            p.p9 = ~btn[BTN_START];
        end
        return p;
    endfunction

endpackage

// File: rtl/genesis_sync_edge.sv
// genesis_sync_edge
//   Two-flop synchroniser for an asynchronous line that idles high, with
//   edge detection on the synchronised level.
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-high reset (all flops to 1)
//   i_async  asynchronous input
//   o_level  synchronised level
//   o_fall   one-cycle pulse: previous synced 1, current synced 0
//   o_rise   one-cycle pulse: previous synced 0, current synced 1
module genesis_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_fall,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;
    assign o_rise  = ~r_prev & r_sync;

endmodule

// File: rtl/genesis_pad_emulator.sv
// genesis_pad_emulator
//   Pad side of the Genesis/Mega Drive 6-button controller protocol. Counts
//   Select falling edges (Fase), resets the count after TIMEOUT_CYCLES with
//   no falling edge, and drives the active-low pad pins from the button
//   vector through a registered pin map.
// Ports:
//   clock_50  50 MHz system clock
//   reset     asynchronous active-high reset
//   Select    host select line (asynchronous)
//   Botoes    12-bit button vector, 1 = pressed
//   Pino1..9  registered pad pins, active low
//   Fase      count of Select falling edges, saturating at 7
module genesis_pad_emulator
    import genesis_pad_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter bit          MODE_6BTN      = 1'b1
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        Select,
    input  logic [11:0] Botoes,
    output logic        Pino1,
    output logic        Pino2,
    output logic        Pino3,
    output logic        Pino4,
    output logic        Pino6,
    output logic        Pino9,
    output logic [2:0]  Fase
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          w_sel;
    logic          w_fall;
    logic          w_rise;

    logic [2:0]    r_fase;
    logic [TW-1:0] r_timer;
    pad_pins_t     r_pins;

    logic [2:0]    w_fase_next;
    logic [TW-1:0] w_timer_next;
    pad_pins_t     w_pins_next;

    genesis_sync_edge u_sync (
        .i_clk   (clock_50),
        .i_rst   (reset),
        .i_async (Select),
        .o_level (w_sel),
        .o_fall  (w_fall),
        .o_rise  (w_rise)
    );

    always_comb begin
        w_fase_next  = r_fase;
        w_timer_next = r_timer;
        if (w_fall) begin
            // A falling edge takes priority over a coincident timeout
            w_timer_next = '0;
            if (r_fase != FASE_MAX) begin
                w_fase_next = r_fase + 3'd1;
            end
        end else begin
            if (r_timer != TIMER_MAX) begin
                w_timer_next = r_timer + 1'b1;
            end
            if (r_timer == TIMER_LAST) begin
                w_fase_next = '0;
            end
        end
        // Map uses the updated Fase so the pins change on the same edge as the count
        w_pins_next = pad_map(w_sel, w_fase_next, Botoes, MODE_6BTN);
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_fase  <= '0;
            r_timer <= '0;
            r_pins  <= '1;
        end else begin
            r_fase  <= w_fase_next;
            r_timer <= w_timer_next;
            r_pins  <= w_pins_next;
        end
    end

    assign Pino1 = r_pins.p1;
    assign Pino2 = r_pins.p2;
    assign Pino3 = r_pins.p3;
    assign Pino4 = r_pins.p4;
    assign Pino6 = r_pins.p6;
    assign Pino9 = r_pins.p9;
    assign Fase  = r_fase;

endmodule

// File: tb/tb_genesis_pad_emulator.sv
// Directed bench for genesis_pad_emulator: a 6-button instance and a
// 3-button instance share clock, reset, Select and buttons. The timeout is
// shortened to 3000 cycles so boundary gaps stay short.
// Pin vectors are compared as {P1,P2,P3,P4,P6,P9}.
module tb_genesis_pad_emulator;

    localparam int unsigned TMO = 3000;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [11:0] btn;

    logic        a_p1, a_p2, a_p3, a_p4, a_p6, a_p9;
    logic        b_p1, b_p2, b_p3, b_p4, b_p6, b_p9;
    logic [2:0]  a_fase, b_fase;
    logic [5:0]  pins6, pins3;

    int n_checks = 0;
    int n_fail   = 0;

    assign pins6 = {a_p1, a_p2, a_p3, a_p4, a_p6, a_p9};
    assign pins3 = {b_p1, b_p2, b_p3, b_p4, b_p6, b_p9};

    genesis_pad_emulator #(.TIMEOUT_CYCLES(TMO), .MODE_6BTN(1'b1)) u_dut6 (
        .clock_50 (clk),
        .reset    (rst),
        .Select   (sel),
        .Botoes   (btn),
        .Pino1    (a_p1),
        .Pino2    (a_p2),
        .Pino3    (a_p3),
        .Pino4    (a_p4),
        .Pino6    (a_p6),
        .Pino9    (a_p9),
        .Fase     (a_fase)
    );

    genesis_pad_emulator #(.TIMEOUT_CYCLES(TMO), .MODE_6BTN(1'b0)) u_dut3 (
        .clock_50 (clk),
        .reset    (rst),
        .Select   (sel),
        .Botoes   (btn),
        .Pino1    (b_p1),
        .Pino2    (b_p2),
        .Pino3    (b_p3),
        .Pino4    (b_p4),
        .Pino6    (b_p6),
        .Pino9    (b_p9),
        .Fase     (b_fase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges and settle just past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_both(input string tag, input logic [5:0] e6, input logic [5:0] e3,
                              input logic [2:0] ef);
        check_eq({tag, "_pins6"}, 32'(pins6), 32'(e6));
        check_eq({tag, "_pins3"}, 32'(pins3), 32'(e3));
        check_eq({tag, "_fase6"}, 32'(a_fase), 32'(ef));
        check_eq({tag, "_fase3"}, 32'(b_fase), 32'(ef));
    endtask

    // Expected pins with Botoes = Up|A|Z
    localparam logic [5:0] HI_NORM = 6'b011111;  // P1 = ~Up
    localparam logic [5:0] LO_3BTN = 6'b010001;  // P1 = ~Up, P3/P4 low, P6 = ~A
    localparam logic [5:0] LO_ID   = 6'b000001;
    localparam logic [5:0] LO_EXT  = 6'b111101;

    initial begin
        logic [5:0] exp6;

        // 1: reset with all buttons pressed
        rst = 1'b1;
        sel = 1'b1;
        btn = 12'hFFF;
        tick(3);
        check_both("rst_held", 6'h3F, 6'h3F, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_both("rst_release", 6'h3F, 6'h3F, 3'd0);
        tick(1);
        check_both("all_pressed_hi", 6'h00, 6'h00, 3'd0);
        btn = 12'h884;

        // 2/4: four low + four high pulses of 1000 cycles
        for (int i = 1; i <= 4; i++) begin
            sel = 1'b0;
            tick(500);
            exp6 = (i == 3) ? LO_ID : (i == 4) ? LO_EXT : LO_3BTN;
            check_both($sformatf("seq_low%0d", i), exp6, LO_3BTN, 3'(i));
            tick(500);
            sel = 1'b1;
            tick(500);
            check_both($sformatf("seq_high%0d", i), HI_NORM, HI_NORM, 3'(i));
            if (i == 3) begin
                // Only Up pressed: 6-button high after ID shows Z (released)
                btn = 12'h800;
                tick(1);
                check_both("ext_high_uponly", 6'b111111, HI_NORM, 3'd3);
                btn = 12'h884;
                tick(499);
            end else begin
                tick(500);
            end
        end

        // 3: fall-to-fall gap just under the timeout keeps counting
        tick(998);
        sel = 1'b0;
        tick(10);
        check_both("gap_short", LO_3BTN, LO_3BTN, 3'd5);
        sel = 1'b1;
        // gap one past the timeout: count restarts at 1
        tick(TMO + 1 - 10);
        sel = 1'b0;
        tick(10);
        check_both("gap_long", LO_3BTN, LO_3BTN, 3'd1);

        // 6: button change with Select steady reaches pins after one edge
        sel = 1'b1;
        tick(500);
        check_both("pre_right", HI_NORM, HI_NORM, 3'd1);
        btn = 12'h984;
        @(negedge clk);
        check_both("right_before_edge", HI_NORM, HI_NORM, 3'd1);
        @(posedge clk);
        #1;
        check_both("right_after_edge", 6'b011011, 6'b011011, 3'd1);
        btn = 12'h884;
        tick(1);
        check_both("right_release", HI_NORM, HI_NORM, 3'd1);

        // 5: reset mid-sequence, then restart
        for (int i = 0; i < 2; i++) begin
            sel = 1'b0;
            tick(1000);
            sel = 1'b1;
            tick(1000);
        end
        #3;
        rst = 1'b1;
        #1;
        check_both("mid_rst_async", 6'h3F, 6'h3F, 3'd0);
        tick(2);
        check_both("mid_rst_held", 6'h3F, 6'h3F, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(5);
        check_both("post_rst_high", HI_NORM, HI_NORM, 3'd0);
        for (int i = 1; i <= 3; i++) begin
            sel = 1'b0;
            tick(500);
            exp6 = (i == 3) ? LO_ID : LO_3BTN;
            check_both($sformatf("restart_low%0d", i), exp6, LO_3BTN, 3'(i));
            sel = 1'b1;
            tick(500);
        end

        // Saturation of Fase at 7
        for (int i = 4; i <= 8; i++) begin
            sel = 1'b0;
            tick(50);
            exp6 = (i == 4) ? LO_EXT : LO_3BTN;
            check_both($sformatf("sat_low%0d", i), exp6, LO_3BTN, (i > 7) ? 3'd7 : 3'(i));
            tick(50);
            sel = 1'b1;
            tick(100);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
